uart_rsp_framer: RTL and testbench
==================================

Name: uart_rsp_framer

Overview:
Transmit-side counterpart of the UART command parser. It captures one response (16-bit address, 8-bit count, 128-bit payload) and serialises it as a 22-byte frame. Bytes are issued one at a time to the UART byte transmitter through a go/done handshake. The block sits between the register/I2C response logic and the UART TX byte engine.

Parameters:
HEAD0, 8'h55, first header byte
HEAD1, 8'hA5, second header byte
TAIL, 8'hF0, final frame byte
GAP_CYCLES, 0, idle Clk cycles inserted after each tx_done before the next byte (0..255)

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
rsp_valid  input  1  response available; sampled with rsp_ready
rsp_ready  output  1  high only in IDLE; a transfer occurs when rsp_valid && rsp_ready
address  input  16  response address
num_cmd  input  8  response count/opcode byte
data  input  128  response payload
tx_data  output  8  byte to transmit; stable from send_go until tx_done
send_go  output  1  one-cycle pulse that starts one byte on the UART TX
tx_done  input  1  one-cycle pulse from the UART TX when the byte has finished
busy  output  1  high from frame capture until the tail byte's tx_done
frame_done  output  1  one-cycle pulse on the tail byte's tx_done

Behaviour:
- Reset values: tx_data=0, send_go=0, busy=0, frame_done=0, rsp_ready=0 while reset is asserted and rising to 1 on the first cycle after release. Internal regs (byte index, gap counter, shadow regs) are cleared.
- Reset takes effect immediately mid-frame. The partial frame is abandoned and the block returns to IDLE.
- Frame byte order (index 0..21):
  - 0: HEAD0
  - 1: HEAD1
  - 2: address[15:8]
  - 3: address[7:0]
  - 4: num_cmd
  - 5..20: data[127:120] down to data[7:0], MSB byte first
  - 21: TAIL
- Capture: on handshake, address/num_cmd/data are registered into shadow regs. Input changes after that have no effect on the frame.
- FSM states:
  - IDLE: rsp_ready=1. Handshake -> LOAD; busy=1 and idx=0 on the next edge.
  - LOAD: tx_data <= byte[idx]; -> SEND.
  - SEND: send_go=1 for exactly one cycle; -> WAIT.
  - WAIT: hold tx_data. On tx_done:
    - if idx==last: frame_done=1, busy=0 -> IDLE
    - else if GAP_CYCLES==0: idx++ -> LOAD
    - else: load gap counter, -> GAP.
  - GAP: count down GAP_CYCLES cycles, then idx++ -> LOAD.
- Latency: handshake edge to first send_go is 2 cycles. tx_done to the next send_go is 2 + GAP_CYCLES cycles.
- tx_done outside WAIT is ignored.
- rsp_valid during busy is not accepted (rsp_ready=0). The response is held upstream.
- Back-to-back frames: rsp_ready returns in the cycle after frame_done. A response held valid is accepted then.
- Byte index is 5 bits. It never wraps, because the last index bounds it.

Optional Feature:
Macro UART_RSP_CHKSUM_EN.
- Defined: an XOR checksum byte is inserted at index 21, computed over frame bytes 2..20. TAIL moves to index 22, giving a 23-byte frame. The checksum accumulates as bytes are loaded in LOAD.
- Undefined: 22-byte frame exactly as above, and no checksum logic is present.

Decomposition:
- Package uart_frame_pkg holds:
  - HEAD0/HEAD1/TAIL defaults
  - FRAME_BYTES (22), or 23 when UART_RSP_CHKSUM_EN is defined
  - byte-index localparams (IDX_ADDR_HI=2, IDX_NUM=4, IDX_DATA0=5, IDX_TAIL)
  - FSM state enum {IDLE, LOAD, SEND, WAIT, GAP}
- The parser and this framer both use the package.
- No sub-module. The byte mux and the FSM are kept in a single module.

Test Plan:
- Single frame: address=16'h1234, num_cmd=8'h03, data=128'h00112233_44556677_8899AABB_CCDDEEFF. A TX model answers tx_done 10 cycles after each send_go. Required byte stream: 55 A5 12 34 03 00 11 … EE FF F0. frame_done pulses once; busy drops with it.
- Handshake timing: rsp_valid is held high for two frames. The first send_go arrives exactly 2 cycles after the handshake. The second frame is accepted the cycle after frame_done. No byte is lost or duplicated.
- Input isolation: after the handshake, address is changed to 16'hFFFF mid-frame. Frame bytes 2/3 still read 12 34.
- Gap: with GAP_CYCLES=5, the distance from each tx_done to the next send_go is exactly 7 cycles.
- Reset mid-frame: Reset_n is asserted after byte 7's send_go. All outputs return to reset values immediately. A new frame after release starts with 55.
- With UART_RSP_CHKSUM_EN defined: the frame from the first scenario is 23 bytes. Byte 21 equals the XOR of bytes 2..20, and byte 22 is F0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared framing constants for the UART command parser and response framer.
// UART_RSP_CHKSUM_EN adds an XOR checksum byte ahead of the tail.
package uart_frame_pkg;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hA5;
    localparam logic [7:0] TAIL_DEF  = 8'hF0;

`ifdef UART_RSP_CHKSUM_EN
    localparam int FRAME_BYTES = 23;
`else
    localparam int FRAME_BYTES = 22;
`endif

    localparam logic [4:0] IDX_ADDR_HI   = 5'd2;
    localparam logic [4:0] IDX_ADDR_LO   = 5'd3;
    localparam logic [4:0] IDX_NUM       = 5'd4;
    localparam logic [4:0] IDX_DATA0     = 5'd5;
    localparam logic [4:0] IDX_DATA_LAST = 5'd20;
    localparam logic [4:0] IDX_CHK       = 5'd21;
    localparam logic [4:0] IDX_TAIL      = 5'(FRAME_BYTES - 1);

    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t LOAD = 3'd1;
    localparam state_t SEND = 3'd2;
    localparam state_t WAIT = 3'd3;
    localparam state_t GAP  = 3'd4;

endpackage

// File: rtl/uart_rsp_framer.sv
// Captures one response and streams it byte by byte to the UART TX engine.
// Define UART_RSP_CHKSUM_EN to insert an XOR checksum byte before the tail.
module uart_rsp_framer
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEAD0      = HEAD0_DEF,
    parameter logic [7:0] HEAD1      = HEAD1_DEF,
    parameter logic [7:0] TAIL       = TAIL_DEF,
    parameter int         GAP_CYCLES = 0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         rsp_valid,
    output logic         rsp_ready,
    input  logic [15:0]  address,
    input  logic [7:0]   num_cmd,
    input  logic [127:0] data,
    output logic [7:0]   tx_data,
    output logic         send_go,
    input  logic         tx_done,
    output logic         busy,
    output logic         frame_done
);

    state_t         state;
    logic [4:0]     idx;
    logic [7:0]     gap_cnt;
    logic [15:0]    addr_q;
    logic [7:0]     num_q;
    logic [127:0]   data_q;
    logic           rdy_en;
    logic [7:0]     cur_byte;
    logic [3:0]     dsel;
    logic           last;
`ifdef UART_RSP_CHKSUM_EN
    logic [7:0]     chk;
`endif

    // rdy_en keeps rsp_ready low through the first edge out of reset
    assign rsp_ready  = (state == IDLE) && rdy_en;
    assign send_go    = (state == SEND);
    assign busy       = (state != IDLE);
    assign last       = (idx == IDX_TAIL);
    assign frame_done = (state == WAIT) && tx_done && last;
    assign dsel       = 4'(IDX_DATA_LAST - idx);

    always_comb begin
        cur_byte = TAIL;
        if (idx == 5'd0)
            cur_byte = HEAD0;
        else if (idx == 5'd1)
            cur_byte = HEAD1;
        else if (idx == IDX_ADDR_HI)
            cur_byte = addr_q[15:8];
        else if (idx == IDX_ADDR_LO)
            cur_byte = addr_q[7:0];
        else if (idx == IDX_NUM)
            cur_byte = num_q;
        else if (idx <= IDX_DATA_LAST)
            cur_byte = data_q[{dsel, 3'b000} +: 8];
`ifdef UART_RSP_CHKSUM_EN
        else if (idx == IDX_CHK)
            cur_byte = chk;
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            idx     <= 5'd0;
            gap_cnt <= 8'd0;
            addr_q  <= 16'd0;
            num_q   <= 8'd0;
            data_q  <= 128'd0;
            tx_data <= 8'd0;
            rdy_en  <= 1'b0;
`ifdef UART_RSP_CHKSUM_EN
            chk     <= 8'd0;
`endif
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: if (rsp_valid && rsp_ready) begin
                    addr_q <= address;
                    num_q  <= num_cmd;
                    data_q <= data;
                    idx    <= 5'd0;
`ifdef UART_RSP_CHKSUM_EN
                    chk    <= 8'd0;
`endif
                    state  <= LOAD;
                end
                LOAD: begin
                    tx_data <= cur_byte;
`ifdef UART_RSP_CHKSUM_EN
                    // checksum is complete by the time idx reaches IDX_CHK
                    if (idx >= IDX_ADDR_HI && idx <= IDX_DATA_LAST)
                        chk <= chk ^ cur_byte;
`endif
                    state <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: if (tx_done) begin
                    if (last) begin
                        state <= IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        idx   <= idx + 5'd1;
                        state <= LOAD;
                    end else begin
                        gap_cnt <= 8'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        idx   <= idx + 5'd1;
                        state <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rsp_framer.sv
// Bench for uart_rsp_framer: a no-gap and a GAP_CYCLES=5 instance share clock
// and reset; a TX model answers each send_go with tx_done 10 cycles later.
module tb_uart_rsp_framer;

    localparam int LAT  = 10;
    localparam int GAPN = 5;
`ifdef UART_RSP_CHKSUM_EN
    localparam int NB = 23;
`else
    localparam int NB = 22;
`endif

    typedef logic [7:0] bq_t[$];

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b1;
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic [15:0]  address [2];
    logic [7:0]   num_cmd [2];
    logic [127:0] data [2];
    logic [7:0]   tx_data [2];
    logic         send_go [2];
    logic         tx_done [2];
    logic         busy [2];
    logic         frame_done [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rec [2][$];
    int go_cyc [2][$];
    int done_cyc [2][$];
    int fd_cnt [2];
    int pend [2];
    int rb [2], gb [2], db [2], fb [2];

    uart_rsp_framer u0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .address(address[0]), .num_cmd(num_cmd[0]), .data(data[0]),
        .tx_data(tx_data[0]), .send_go(send_go[0]), .tx_done(tx_done[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    uart_rsp_framer #(.GAP_CYCLES(GAPN)) u1 (
        .Clk(Clk), .Reset_n(Reset_n),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .address(address[1]), .num_cmd(num_cmd[1]), .data(data[1]),
        .tx_data(tx_data[1]), .send_go(send_go[1]), .tx_done(tx_done[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // TX byte engine model
    initial begin
        for (int u = 0; u < 2; u++) begin
            tx_done[u] = 1'b0;
            pend[u] = 0;
        end
        forever begin
            @(posedge Clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                tx_done[u] = 1'b0;
                if (!Reset_n) begin
                    pend[u] = 0;
                end else begin
                    if (pend[u] > 0) begin
                        pend[u]--;
                        if (pend[u] == 0) begin
                            tx_done[u] = 1'b1;
                            done_cyc[u].push_back(cyc);
                        end
                    end
                    if (send_go[u]) begin
                        rec[u].push_back(tx_data[u]);
                        go_cyc[u].push_back(cyc);
                        pend[u] = LAT;
                    end
                end
            end
        end
    end

    initial begin
        fd_cnt[0] = 0;
        fd_cnt[1] = 0;
        forever begin
            @(negedge Clk);
            for (int u = 0; u < 2; u++)
                if (frame_done[u] === 1'b1) fd_cnt[u]++;
        end
    end

    function automatic bq_t build_frame(input logic [15:0] a, input logic [7:0] n, input logic [127:0] d);
        bq_t f;
        logic [7:0] x;
        f.push_back(8'h55);
        f.push_back(8'hA5);
        f.push_back(a[15:8]);
        f.push_back(a[7:0]);
        f.push_back(n);
        for (int i = 15; i >= 0; i--) f.push_back(d[i*8 +: 8]);
`ifdef UART_RSP_CHKSUM_EN
        x = 8'h00;
        for (int i = 2; i <= 20; i++) x = x ^ f[i];
        f.push_back(x);
`else
        x = 8'h00;
`endif
        f.push_back(8'hF0);
        return f;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rebase(input int u);
        rb[u] = rec[u].size();
        gb[u] = go_cyc[u].size();
        db[u] = done_cyc[u].size();
        fb[u] = fd_cnt[u];
    endtask

    task automatic hs(input int u, input logic [15:0] a, input logic [7:0] n, input logic [127:0] d, output int hc);
        int k = 0;
        @(negedge Clk);
        while (rsp_ready[u] !== 1'b1 && k < 2000) begin
            @(negedge Clk);
            k++;
        end
        checks++;
        if (rsp_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL hs_ready_u%0d: rsp_ready=%b expected 1", u, rsp_ready[u]);
        end
        address[u] = a;
        num_cmd[u] = n;
        data[u] = d;
        rsp_valid[u] = 1'b1;
        hc = cyc;
        @(negedge Clk);
        rsp_valid[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, output int fc);
        int k = 0;
        @(negedge Clk);
        while (frame_done[u] !== 1'b1 && k < 2000) begin
            @(negedge Clk);
            k++;
        end
        fc = cyc;
        checks++;
        if (frame_done[u] !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_timeout_u%0d: frame_done=%b expected 1", u, frame_done[u]);
        end
    endtask

    task automatic check_frame(input int u, input bq_t exp, input string tag);
        int n;
        n = rec[u].size() - rb[u];
        checks++;
        if (n != exp.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes expected %0d", tag, n, exp.size());
        end
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checks++;
            if (rec[u][rb[u] + i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h expected %h", tag, i, rec[u][rb[u] + i], exp[i]);
            end
        end
    endtask

    task automatic check_spacing(input int u, input int hc, input int gapc, input string tag);
        checks++;
        if (go_cyc[u].size() <= gb[u] || go_cyc[u][gb[u]] != hc + 2) begin
            errors++;
            $display("FAIL %s_first_go: got cycle %0d expected %0d", tag,
                     (go_cyc[u].size() > gb[u]) ? go_cyc[u][gb[u]] : -1, hc + 2);
        end
        for (int k = 0; k < NB - 1; k++) begin
            if (go_cyc[u].size() > gb[u] + k + 1 && done_cyc[u].size() > db[u] + k) begin
                checks++;
                if (go_cyc[u][gb[u] + k + 1] - done_cyc[u][db[u] + k] != 2 + gapc) begin
                    errors++;
                    $display("FAIL %s_spacing%0d: got %0d cycles expected %0d", tag, k,
                             go_cyc[u][gb[u] + k + 1] - done_cyc[u][db[u] + k], 2 + gapc);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rsp_valid[u] = 1'b0;
            address[u] = 16'h0;
            num_cmd[u] = 8'h0;
            data[u] = 128'h0;
        end
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (tx_data[0] !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data[0]); end
        checks++;
        if (send_go[0] !== 1'b0) begin errors++; $display("FAIL reset_send_go: got %b expected 0", send_go[0]); end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        checks++;
        if (frame_done[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done[0]); end
        checks++;
        if (rsp_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready: got %b expected 0", rsp_ready[0]); end
        Reset_n = 1'b1;
        @(negedge Clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rsp_ready[u] !== 1'b1) begin errors++; $display("FAIL release_rsp_ready_u%0d: got %b expected 1", u, rsp_ready[u]); end
        end
    endtask

    task automatic test_single();
        int hc, fc;
        bq_t exp;
        exp = build_frame(16'h1234, 8'h03, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        rebase(0);
        hs(0, 16'h1234, 8'h03, 128'h00112233_44556677_8899AABB_CCDDEEFF, hc);
        wait_done(0, fc);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_at_done: got %b expected 1", busy[0]); end
        @(negedge Clk);
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy[0]); end
        checks++;
        if (rsp_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b expected 1", rsp_ready[0]); end
        repeat (3) @(negedge Clk);
        checks++;
        if (fd_cnt[0] - fb[0] != 1) begin errors++; $display("FAIL single_frame_done_count: got %0d expected 1", fd_cnt[0] - fb[0]); end
        check_frame(0, exp, "single");
        check_spacing(0, hc, 0, "single");
    endtask

    task automatic test_back_to_back();
        int hc1, fc1, fc2, k;
        logic [15:0] a1, a2;
        logic [7:0] n1, n2;
        logic [127:0] d1, d2;
        bq_t exp;
        a1 = 16'($urandom); n1 = 8'($urandom); d1 = rand128();
        a2 = 16'($urandom); n2 = 8'($urandom); d2 = rand128();
        exp = {build_frame(a1, n1, d1), build_frame(a2, n2, d2)};
        rebase(0);
        k = 0;
        @(negedge Clk);
        while (rsp_ready[0] !== 1'b1 && k < 100) begin @(negedge Clk); k++; end
        address[0] = a1; num_cmd[0] = n1; data[0] = d1; rsp_valid[0] = 1'b1;
        hc1 = cyc;
        @(negedge Clk);
        address[0] = a2; num_cmd[0] = n2; data[0] = d2;
        checks++;
        if (rsp_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", rsp_ready[0]); end
        wait_done(0, fc1);
        @(negedge Clk);
        checks++;
        if (rsp_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b expected 1", rsp_ready[0]); end
        @(negedge Clk);
        rsp_valid[0] = 1'b0;
        wait_done(0, fc2);
        repeat (3) @(negedge Clk);
        checks++;
        if (fd_cnt[0] - fb[0] != 2) begin errors++; $display("FAIL b2b_frame_done_count: got %0d expected 2", fd_cnt[0] - fb[0]); end
        checks++;
        if (go_cyc[0].size() <= gb[0] + NB || go_cyc[0][gb[0] + NB] != fc1 + 3) begin
            errors++;
            $display("FAIL b2b_second_go: got cycle %0d expected %0d",
                     (go_cyc[0].size() > gb[0] + NB) ? go_cyc[0][gb[0] + NB] : -1, fc1 + 3);
        end
        check_frame(0, exp, "b2b");
        check_spacing(0, hc1, 0, "b2b");
    endtask

    task automatic test_isolation();
        int hc, fc;
        bq_t exp;
        exp = build_frame(16'h1234, 8'h03, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        rebase(0);
        hs(0, 16'h1234, 8'h03, 128'h00112233_44556677_8899AABB_CCDDEEFF, hc);
        repeat (2) @(negedge Clk);
        address[0] = 16'hFFFF;
        num_cmd[0] = 8'($urandom);
        data[0] = rand128();
        wait_done(0, fc);
        check_frame(0, exp, "isolation");
    endtask

    task automatic test_reset_mid();
        int hc, fc, k;
        logic [15:0] a;
        logic [7:0] n;
        logic [127:0] d;
        bq_t exp;
        rebase(0);
        hs(0, 16'($urandom), 8'($urandom), rand128(), hc);
        k = 0;
        while (go_cyc[0].size() - gb[0] < 8 && k < 2000) begin @(negedge Clk); k++; end
        checks++;
        if (go_cyc[0].size() - gb[0] != 8) begin errors++; $display("FAIL rstmid_reach_byte7: got %0d sends expected 8", go_cyc[0].size() - gb[0]); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (tx_data[0] !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data[0]); end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
        checks++;
        if ({send_go[0], frame_done[0], rsp_ready[0]} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_ctrl: got go/done/ready=%b expected 000", {send_go[0], frame_done[0], rsp_ready[0]});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        rebase(0);
        a = 16'($urandom); n = 8'($urandom); d = rand128();
        exp = build_frame(a, n, d);
        hs(0, a, n, d, hc);
        wait_done(0, fc);
        checks++;
        if (rec[0].size() <= rb[0] || rec[0][rb[0]] !== 8'h55) begin errors++; $display("FAIL rstmid_first_byte: expected 55 as first byte after reset"); end
        check_frame(0, exp, "rstmid");
        check_spacing(0, hc, 0, "rstmid");
    endtask

    task automatic test_gap();
        int hc, fc;
        logic [15:0] a;
        logic [7:0] n;
        logic [127:0] d;
        bq_t exp;
        a = 16'($urandom); n = 8'($urandom); d = rand128();
        exp = build_frame(a, n, d);
        rebase(1);
        hs(1, a, n, d, hc);
        wait_done(1, fc);
        check_frame(1, exp, "gap");
        check_spacing(1, hc, GAPN, "gap");
    endtask

    task automatic test_random();
        int hc, fc;
        logic [15:0] a;
        logic [7:0] n;
        logic [127:0] d;
        bq_t exp;
        for (int r = 0; r < 3; r++) begin
            a = 16'($urandom); n = 8'($urandom); d = rand128();
            exp = build_frame(a, n, d);
            rebase(0);
            hs(0, a, n, d, hc);
            wait_done(0, fc);
            check_frame(0, exp, "random");
            check_spacing(0, hc, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_isolation();
        test_reset_mid();
        test_gap();
        test_random();
        repeat (5) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
